// File: rtl/wavetable_loader_pkg.sv
// Shared types for the wavetable loader: table geometry, amplitude type, loader FSM states.
package wavetable_loader_pkg;

  localparam int unsigned WAVETABLE_N    = 10;
  localparam int unsigned AMPLITUDE_BITS = 16;

  typedef logic [AMPLITUDE_BITS-1:0] amplitude_type;
  typedef logic [WAVETABLE_N-1:0]    table_index_type;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } loader_state;

endpackage

// File: rtl/wavetable_bank_ram.sv
// Simple dual-port RAM holding both banks, addressed {bank, idx}; one write port, one registered read port.
module wavetable_bank_ram #(
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] q
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register is cleared by reset; the array itself is never cleared.
  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else       q <= mem[raddr];
  end

endmodule

// File: rtl/wavetable_loader.sv
// Double-buffered wavetable: streaming writer fills the inactive bank, oscillator reads idx and idx+1
// from the active bank, banks swap atomically once a full table has been written.
module wavetable_loader
  import wavetable_loader_pkg::*;
#(
  parameter int unsigned TABLE_BITS = WAVETABLE_N,
  parameter int unsigned DATA_BITS  = AMPLITUDE_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic                  in_first,
  input  logic [TABLE_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0]  rd_q_a,
  output logic [DATA_BITS-1:0]  rd_q_b,
  output logic                  active_bank,
  output logic                  table_valid,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned ADDR_BITS = TABLE_BITS + 1;
  localparam logic [TABLE_BITS-1:0] LAST_IDX = '1;

  loader_state           state, state_nx;
  logic [TABLE_BITS-1:0] idx, idx_nx, widx;
  logic                  bank_nx, valid_nx, done_nx, error_nx, we;
  logic                  fire;
  logic [TABLE_BITS-1:0] rd_addr_b;

  // Ready depends only on state and reset, never on in_valid.
  assign in_ready  = ~reset & (state != COMMIT);
  assign fire      = in_valid & in_ready;
  assign rd_addr_b = rd_addr + TABLE_BITS'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      active_bank <= 1'b0;
      table_valid <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      active_bank <= bank_nx;
      table_valid <= valid_nx;
      load_done   <= done_nx;
      load_error  <= error_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    bank_nx  = active_bank;
    valid_nx = table_valid;
    done_nx  = 1'b0;
    error_nx = 1'b0;
    we       = 1'b0;
    widx     = idx;
    case (state)
      IDLE: begin
        if (fire) begin
          if (in_first) begin
            we       = 1'b1;
            widx     = '0;
            idx_nx   = TABLE_BITS'(1);
            state_nx = LOAD;
          end else begin
            error_nx = 1'b1;
          end
        end
      end
      LOAD: begin
        if (fire) begin
          we = 1'b1;
          // A fresh in_first restarts the table; the partial data is simply overwritten.
          if (in_first) begin
            widx     = '0;
            idx_nx   = TABLE_BITS'(1);
            error_nx = 1'b1;
          end else begin
            idx_nx = idx + TABLE_BITS'(1);
            if (idx == LAST_IDX) state_nx = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_nx = IDLE;
        idx_nx   = '0;
        bank_nx  = ~active_bank;
        valid_nx = 1'b1;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Both RAMs take identical writes so each provides one independent read port.
  wavetable_bank_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_ram_a (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr ({~active_bank, widx}),
    .wdata (in_data),
    .raddr ({active_bank, rd_addr}),
    .q     (rd_q_a)
  );

  wavetable_bank_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_ram_b (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr ({~active_bank, widx}),
    .wdata (in_data),
    .raddr ({active_bank, rd_addr_b}),
    .q     (rd_q_b)
  );

endmodule

// File: tb/tb_wavetable_loader.sv
// Self-checking bench for wavetable_loader (TABLE_BITS=4): reference model plus read-data scoreboard.
module tb_wavetable_loader;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_first;
  logic [3:0]  rd_addr;
  logic [15:0] rd_q_a;
  logic [15:0] rd_q_b;
  logic        active_bank;
  logic        table_valid;
  logic        load_done;
  logic        load_error;

  wavetable_loader #(
    .TABLE_BITS (4),
    .DATA_BITS  (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_first    (in_first),
    .rd_addr     (rd_addr),
    .rd_q_a      (rd_q_a),
    .rd_q_b      (rd_q_b),
    .active_bank (active_bank),
    .table_valid (table_valid),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        care;
    logic [15:0] qa;
    logic [15:0] qb;
  } rd_exp_t;

  rd_exp_t     sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          n_error_pulses = 0;
  logic        last_fire;

  // Reference model state
  int          m_state = 0;   // 0 idle, 1 load, 2 commit
  int          m_idx = 0;
  logic        m_bank = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] mem [2][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict, advance past the edge, compare.
  task automatic cycle(input logic rst, input logic v, input logic f,
                       input logic [15:0] d, input logic [3:0] a);
    logic    exp_ready, fire;
    logic [3:0] a1;
    rd_exp_t e, o;
    reset = rst; in_valid = v; in_first = f; in_data = d; rd_addr = a;
    #1;
    exp_ready = !rst && (m_state != 2);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    fire = v && exp_ready;
    last_fire = fire;
    a1 = a + 4'd1;
    e.care = rst || m_valid;
    e.qa = rst ? 16'h0 : mem[m_bank][a];
    e.qb = rst ? 16'h0 : mem[m_bank][a1];
    sb.push_back(e);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_state = 0; m_idx = 0; m_bank = 1'b0; m_valid = 1'b0;
    end else begin
      case (m_state)
        0: if (fire) begin
             if (f) begin mem[!m_bank][0] = d; m_idx = 1; m_state = 1; end
             else m_err = 1'b1;
           end
        1: if (fire) begin
             if (f) begin mem[!m_bank][0] = d; m_idx = 1; m_err = 1'b1; end
             else begin
               mem[!m_bank][m_idx] = d;
               if (m_idx == 15) begin m_state = 2; m_idx = 0; end
               else m_idx = m_idx + 1;
             end
           end
        default: begin
          m_bank = !m_bank; m_valid = 1'b1; m_done = 1'b1; m_state = 0; m_idx = 0;
        end
      endcase
    end
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      if (o.care) begin
        check("rd_q_a", 32'(rd_q_a), 32'(o.qa));
        check("rd_q_b", 32'(rd_q_b), 32'(o.qb));
      end
    end
    check("load_done", 32'(load_done), 32'(m_done));
    check("load_error", 32'(load_error), 32'(m_err));
    check("active_bank", 32'(active_bank), 32'(m_bank));
    check("table_valid", 32'(table_valid), 32'(m_valid));
    if (load_done) n_done++;
    if (load_error) n_error_pulses++;
  endtask

  task automatic idle(input logic [3:0] a);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, a);
  endtask

  task automatic load_table(input logic [15:0] base, input logic [15:0] step, input logic [3:0] a);
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 1'b1, i == 0, 16'(base + 16'(i) * step), a);
    idle(a);
    idle(a);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) idle(4'(i));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; rd_addr = '0;

    cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
    check("rst_active_bank", 32'(active_bank), 32'd0);
    check("rst_table_valid", 32'(table_valid), 32'd0);
    idle(4'd0);

    // Basic load
    n_done = 0;
    load_table(16'h0000, 16'h0100, 4'd0);
    check("basic_done_count", 32'(n_done), 32'd1);
    check("basic_bank", 32'(active_bank), 32'd1);
    check("basic_valid", 32'(table_valid), 32'd1);
    idle(4'd3);
    check("basic_q_a", 32'(rd_q_a), 32'h0300);
    check("basic_q_b", 32'(rd_q_b), 32'h0400);

    // Wrap and sequential sweep
    idle(4'd15);
    check("wrap_q_a", 32'(rd_q_a), 32'h0F00);
    check("wrap_q_b", 32'(rd_q_b), 32'h0000);
    sweep();

    // Swap boundary: read address 5 every cycle while the new table loads
    idle(4'd5);
    check("swap_pre_q_a", 32'(rd_q_a), 32'h0500);
    n_done = 0;
    load_table(16'h1000, 16'h0001, 4'd5);
    check("swap_done_count", 32'(n_done), 32'd1);
    check("swap_post_q_a", 32'(rd_q_a), 32'h1005);
    check("swap_post_q_b", 32'(rd_q_b), 32'h1006);

    // Protocol error in IDLE: sample dropped, nothing committed
    n_error_pulses = 0;
    cycle(1'b0, 1'b1, 1'b0, 16'hAAAA, 4'd0);
    check("idle_err_pulse", 32'(load_error), 32'd1);
    idle(4'd0);
    check("idle_err_valid", 32'(table_valid), 32'd1);
    sweep();

    // Protocol error in LOAD: restart after 5 samples
    n_done = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, i == 0, 16'(16'h2000 + i), 4'd0);
    cycle(1'b0, 1'b1, 1'b1, 16'h3000, 4'd0);
    check("load_err_pulse", 32'(load_error), 32'd1);
    for (int i = 1; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 16'(16'h3000 + i), 4'd0);
    idle(4'd0);
    idle(4'd0);
    check("restart_err_count", 32'(n_error_pulses), 32'd2);
    check("restart_done_count", 32'(n_done), 32'd1);
    sweep();

    // Backpressure: random valid gaps
    n_done = 0;
    cnt = 0;
    for (int k = 0; k < 400 && cnt < 16; k++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), cnt == 0, 16'(16'h4000 + cnt), 4'(k));
      if (last_fire) cnt++;
    end
    check("bp_count", 32'(cnt), 32'd16);
    idle(4'd0);
    idle(4'd0);
    check("bp_done_count", 32'(n_done), 32'd1);
    sweep();

    // Reset in the middle of a load
    n_done = 0;
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, i == 0, 16'(16'h5000 + i), 4'd7);
    cycle(1'b1, 1'b1, 1'b0, 16'h5009, 4'd7);
    check("midrst_q_a", 32'(rd_q_a), 32'd0);
    check("midrst_q_b", 32'(rd_q_b), 32'd0);
    check("midrst_bank", 32'(active_bank), 32'd0);
    check("midrst_valid", 32'(table_valid), 32'd0);
    for (int i = 0; i < 4; i++) idle(4'd7);
    check("midrst_no_done", 32'(n_done), 32'd0);
    load_table(16'h6000, 16'h0003, 4'd2);
    check("reload_done_count", 32'(n_done), 32'd1);
    check("reload_bank", 32'(active_bank), 32'd1);
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
